// File: rtl/fetch_buffer_if.sv
// Instruction-memory bus between the fetch buffer (master) and memory (slave).
// Handshake: the master raises mem_req with a word-aligned mem_addr and holds
// both stable until the slave answers with a single-cycle mem_ack pulse that
// carries FETCH_W words on mem_rdata. Only one request is ever outstanding.
interface fetch_buffer_if #(
    parameter int FETCH_W = 6
) ();
    logic                   mem_req;
    logic [31:0]            mem_addr;
    logic                   mem_ack;
    logic [32*FETCH_W-1:0]  mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: a DEPTH-entry circular queue filled in FETCH_W-word
// beats from instruction memory, presenting ISSUE_W in-order slots plus the PC
// of slot 0 to the scheduler. A redirect flushes the queue and restarts fetch;
// a response already in flight at redirect time is drained and discarded.
module fetch_buffer #(
    parameter int          DEPTH    = 12,
    parameter int          FETCH_W  = 6,
    parameter int          ISSUE_W  = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CW       = $clog2(ISSUE_W + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    fetch_buffer_if.master               mem,
    input  logic [CW-1:0]                consume,
    input  logic                         redirect,
    input  logic [31:0]                  redirect_pc,
    output logic [32*ISSUE_W-1:0]        instr,
    output logic [ISSUE_W-1:0]           instr_valid,
    output logic [31:0]                  pc0,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic [1:0]                   dbg_state_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // A new beat is only requested when it is guaranteed to fit.
    localparam logic [CNT_W-1:0] SPACE_MAX  = CNT_W'(DEPTH - FETCH_W);
    localparam logic [PTR_W:0]   DEPTH_EXT  = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   FETCH_INC  = (PTR_W + 1)'(FETCH_W);
    localparam logic [CNT_W-1:0] FETCH_CNT  = CNT_W'(FETCH_W);
    localparam logic [31:0]      BEAT_BYTES = 32'(4 * FETCH_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q;
    logic               mem_req_q;
    logic [31:0]        mem_addr_q;

    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        pc0_q, pc0_d;
    logic [31:0]        store_q [DEPTH];

    logic [CNT_W-1:0]   consume_ext;
    logic [CNT_W-1:0]   eff;
    logic               ack_take;
    logic               space_ok;
    logic               unused_rpc_bits;

    // Pointer add modulo DEPTH; both operands are below DEPTH so one
    // conditional subtract is enough, and DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] ptr,
                                                  input logic [PTR_W:0]   inc);
        logic [PTR_W:0] sum;
        sum = {1'b0, ptr} + inc;
        if (sum >= DEPTH_EXT) begin
            sum = sum - DEPTH_EXT;
        end
        return sum[PTR_W-1:0];
    endfunction

    // The low address bits of a redirect target are ignored.
    assign unused_rpc_bits = ^redirect_pc[1:0];

    // Consumption is clamped to what the buffer actually holds.
    assign consume_ext = CNT_W'(consume);
    assign eff         = (consume_ext > count_q) ? count_q : consume_ext;

    // A response is kept only in REQ and only when no redirect arrives with it.
    assign ack_take = (state_q == ST_REQ) && mem.mem_ack && !redirect;
    assign space_ok = (count_q <= SPACE_MAX);

    // Next-state for queue pointers, occupancy and PCs; redirect wins over all.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;
        pc0_d      = pc0_q;
        if (redirect) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            pc0_d      = {redirect_pc[31:2], 2'b00};
        end else begin
            head_d  = wrap_add(head_q, (PTR_W + 1)'(eff));
            pc0_d   = pc0_q + (32'(eff) << 2);
            count_d = count_q - eff;
            if (ack_take) begin
                tail_d     = wrap_add(tail_q, FETCH_INC);
                count_d    = count_q - eff + FETCH_CNT;
                fetch_pc_d = fetch_pc_q + BEAT_BYTES;
            end
        end
    end

    // Queue pointer, occupancy and PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            fetch_pc_q <= RESET_PC;
            pc0_q      <= RESET_PC;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
            pc0_q      <= pc0_d;
        end
    end

    // Storage: an accepted beat lands at tail..tail+FETCH_W-1, wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                store_q[i] <= '0;
            end
        end else if (ack_take) begin
            for (int k = 0; k < FETCH_W; k++) begin
                store_q[wrap_add(tail_q, (PTR_W + 1)'(k))] <= mem.mem_rdata[32*k +: 32];
            end
        end
    end

    // Fetch FSM with registered request and address; the address is captured
    // on entry to REQ so it stays stable through a redirect-induced DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!redirect && space_ok) begin
                        state_q    <= ST_REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= fetch_pc_q;
                    end
                end
                ST_REQ: begin
                    if (mem.mem_ack) begin
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                    end else if (redirect) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (mem.mem_ack) begin
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Issue slots read straight from storage at head; count gates validity.
    always_comb begin
        instr       = '0;
        instr_valid = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            instr[32*i +: 32] = store_q[wrap_add(head_q, (PTR_W + 1)'(i))];
            instr_valid[i]    = (count_q > CNT_W'(i));
        end
    end

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;
    assign pc0          = pc0_q;
    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: a scripted memory responder plus a
// reference model whose expected instruction stream lives in exp_q.
module tb_fetch_buffer;

    localparam int DEPTH   = 12;
    localparam int FETCH_W = 6;
    localparam int ISSUE_W = 2;
    localparam int CW      = 2;
    localparam int CNT_W   = 4;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [CW-1:0]          consume;
    logic                   redirect;
    logic [31:0]            redirect_pc;
    logic [32*ISSUE_W-1:0]  instr;
    logic [ISSUE_W-1:0]     instr_valid;
    logic [31:0]            pc0;
    logic [CNT_W-1:0]       count;
    logic                   empty;
    logic [1:0]             dbg_state;

    fetch_buffer_if #(.FETCH_W(FETCH_W)) mem_if ();

    fetch_buffer #(
        .DEPTH(DEPTH), .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W),
        .RESET_PC(32'h0000_0000), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .mem(mem_if.master),
        .consume(consume), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr(instr), .instr_valid(instr_valid), .pc0(pc0),
        .count(count), .empty(empty), .dbg_state_o(dbg_state)
    );

    // scoreboard and reference model
    logic [31:0] exp_q[$];
    logic [31:0] m_pc0;
    logic [31:0] m_fetch_pc;
    logic [31:0] m_addr;
    int          m_st;      // 0 idle, 1 request outstanding, 2 draining
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h11 + (a >> 2);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_pc0 = 32'h0; m_fetch_pc = 32'h0; m_addr = 32'h0; m_st = 0;
    endtask

    // driver: one cycle of stimulus; memory data follows the requested address
    task automatic drive(input int cons, input bit ack, input bit redir, input logic [31:0] rpc);
        int  eff;
        int  sz;
        bit  taken;
        consume        = CW'(cons);
        redirect       = redir;
        redirect_pc    = rpc;
        mem_if.mem_ack = ack;
        for (int k = 0; k < FETCH_W; k++)
            mem_if.mem_rdata[32*k +: 32] = word_at(mem_if.mem_addr + 32'(4*k));
        sz    = exp_q.size();
        taken = (m_st == 1) && ack && !redir;
        case (m_st)
            0: if (!redir && (DEPTH - sz) >= FETCH_W) begin m_st = 1; m_addr = m_fetch_pc; end
            1: if (ack) m_st = 0; else if (redir) m_st = 2;
            default: if (ack) m_st = 0;
        endcase
        if (redir) begin
            exp_q.delete();
            m_pc0 = rpc & ~32'h3;
            m_fetch_pc = m_pc0;
        end else begin
            eff = (cons < sz) ? cons : sz;
            repeat (eff) void'(exp_q.pop_front());
            m_pc0 += 32'(4*eff);
            if (taken) begin
                for (int k = 0; k < FETCH_W; k++) exp_q.push_back(word_at(m_fetch_pc + 32'(4*k)));
                m_fetch_pc += 32'(4*FETCH_W);
            end
        end
        @(posedge clk); #1;
        consume = '0; redirect = 1'b0; mem_if.mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; consume = '0; redirect = 1'b0; redirect_pc = '0;
        mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        model_reset();
        checks++; if (mem_if.mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", mem_if.mem_req); end
        checks++; if (mem_if.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", mem_if.mem_addr); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b exp 1", empty); end
        checks++; if (instr_valid !== 2'b00) begin errors++; $display("FAIL rst_valid got %b exp 00", instr_valid); end
        checks++; if (instr !== 64'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", instr); end
        checks++; if (pc0 !== 32'h0) begin errors++; $display("FAIL rst_pc0 got %h exp 0", pc0); end
        drive(0, 0, 0, 0);
        checks++; if (mem_if.mem_req !== 1'b1) begin errors++; $display("FAIL cyc2_req got %b exp 1", mem_if.mem_req); end
        checks++; if (mem_if.mem_addr !== 32'h0) begin errors++; $display("FAIL cyc2_addr got %h exp 0", mem_if.mem_addr); end
    endtask

    task automatic test_first_fetch();
        repeat (3) begin
            drive(0, 0, 0, 0);
            checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 32'h0) begin errors++; $display("FAIL hold_req got %b/%h exp 1/0", mem_if.mem_req, mem_if.mem_addr); end
        end
        drive(0, 1, 0, 0);
        checks++; if (count !== 4'd6) begin errors++; $display("FAIL ff_count got %0d exp 6", count); end
        checks++; if (instr !== {32'h12, 32'h11}) begin errors++; $display("FAIL ff_instr got %h exp 0000001200000011", instr); end
        checks++; if (instr_valid !== 2'b11) begin errors++; $display("FAIL ff_valid got %b exp 11", instr_valid); end
        checks++; if (pc0 !== 32'h0) begin errors++; $display("FAIL ff_pc0 got %h exp 0", pc0); end
        checks++; if (mem_if.mem_req !== 1'b0) begin errors++; $display("FAIL ff_idle got %b exp 0", mem_if.mem_req); end
        drive(0, 0, 0, 0);
        checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 32'h18) begin errors++; $display("FAIL ff_next got %b/%h exp 1/00000018", mem_if.mem_req, mem_if.mem_addr); end
    endtask

    task automatic test_fill_drain();
        bit ev;
        drive(0, 1, 0, 0);
        checks++; if (count !== 4'd12) begin errors++; $display("FAIL fill_count got %0d exp 12", count); end
        drive(0, 0, 0, 0);
        checks++; if (mem_if.mem_req !== 1'b0) begin errors++; $display("FAIL full_noreq got %b exp 0", mem_if.mem_req); end
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < ISSUE_W; i++) begin
                ev = (exp_q.size() > i);
                checks++; if (instr_valid[i] !== ev) begin errors++; $display("FAIL drain_valid%0d got %b exp %b", i, instr_valid[i], ev); end
                if (ev) begin checks++; if (instr[32*i +: 32] !== exp_q[i]) begin errors++; $display("FAIL drain_slot%0d got %h exp %h", i, instr[32*i +: 32], exp_q[i]); end end
            end
            checks++; if (pc0 !== 32'(8*c)) begin errors++; $display("FAIL drain_pc0 got %h exp %h", pc0, 32'(8*c)); end
            drive(2, 0, 0, 0);
            checks++; if (count !== CNT_W'(10 - 2*c)) begin errors++; $display("FAIL drain_count got %0d exp %0d", count, 10 - 2*c); end
            checks++; if (mem_if.mem_req !== 1'b0) begin errors++; $display("FAIL drain_early_req got %b exp 0", mem_if.mem_req); end
        end
        checks++; if (pc0 !== 32'h18) begin errors++; $display("FAIL drain_pc0_end got %h exp 00000018", pc0); end
        drive(0, 0, 0, 0);
        checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 32'h30) begin errors++; $display("FAIL refetch got %b/%h exp 1/00000030", mem_if.mem_req, mem_if.mem_addr); end
    endtask

    task automatic test_wrap();
        bit ev;
        drive(0, 1, 0, 0);
        checks++; if (count !== 4'd12) begin errors++; $display("FAIL wrap_count got %0d exp 12", count); end
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < ISSUE_W; i++) begin
                ev = (exp_q.size() > i);
                checks++; if (instr_valid[i] !== ev) begin errors++; $display("FAIL wrap_valid%0d got %b exp %b", i, instr_valid[i], ev); end
                if (ev) begin checks++; if (instr[32*i +: 32] !== exp_q[i]) begin errors++; $display("FAIL wrap_slot%0d got %h exp %h", i, instr[32*i +: 32], exp_q[i]); end end
            end
            checks++; if (pc0 !== m_pc0) begin errors++; $display("FAIL wrap_pc0 got %h exp %h", pc0, m_pc0); end
            if (c == 5) begin
                checks++; if (instr[63:32] !== 32'h1d) begin errors++; $display("FAIL wrap_edge got %h exp 0000001d", instr[63:32]); end
            end
            drive(1, 0, 0, 0);
            checks++; if (mem_if.mem_req !== (m_st != 0)) begin errors++; $display("FAIL wrap_req got %b exp %b", mem_if.mem_req, (m_st != 0)); end
        end
        checks++; if (count !== 4'd4 || pc0 !== 32'h38) begin errors++; $display("FAIL wrap_end got %0d/%h exp 4/00000038", count, pc0); end
        checks++; if (mem_if.mem_addr !== m_addr) begin errors++; $display("FAIL wrap_addr got %h exp %h", mem_if.mem_addr, m_addr); end
    endtask

    task automatic test_back_to_back();
        drive(2, 1, 0, 0);
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL b2b_count got %0d exp 8", count); end
        checks++; if (pc0 !== 32'h40) begin errors++; $display("FAIL b2b_pc0 got %h exp 00000040", pc0); end
        checks++; if (instr !== {32'h22, 32'h21}) begin errors++; $display("FAIL b2b_instr got %h exp 0000002200000021", instr); end
        drive(2, 0, 0, 0);
        checks++; if (instr !== {exp_q[1], exp_q[0]} || exp_q[0] !== 32'h23) begin errors++; $display("FAIL b2b_tail got %h exp 0000002400000023", instr); end
        checks++; if (count !== 4'd6) begin errors++; $display("FAIL b2b_count2 got %0d exp 6", count); end
    endtask

    task automatic test_underflow();
        drive(2, 0, 0, 0);
        drive(2, 0, 0, 0);
        drive(1, 0, 0, 0);
        checks++; if (count !== 4'd1 || instr_valid !== 2'b01) begin errors++; $display("FAIL uf_pre got %0d/%b exp 1/01", count, instr_valid); end
        checks++; if (pc0 !== 32'h5c || instr[31:0] !== exp_q[0]) begin errors++; $display("FAIL uf_pre_pc got %h/%h exp 0000005c/%h", pc0, instr[31:0], exp_q[0]); end
        drive(2, 0, 0, 0);
        checks++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL uf_count got %0d/%b exp 0/1", count, empty); end
        checks++; if (instr_valid !== 2'b00) begin errors++; $display("FAIL uf_valid got %b exp 00", instr_valid); end
        checks++; if (pc0 !== 32'h60) begin errors++; $display("FAIL uf_pc0 got %h exp 00000060", pc0); end
        checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 32'h60) begin errors++; $display("FAIL uf_req got %b/%h exp 1/00000060", mem_if.mem_req, mem_if.mem_addr); end
    endtask

    task automatic test_redirect_drain();
        drive(2, 0, 1, 32'h103);
        checks++; if (count !== 4'd0 || instr_valid !== 2'b00) begin errors++; $display("FAIL rd_flush got %0d/%b exp 0/00", count, instr_valid); end
        checks++; if (pc0 !== 32'h100) begin errors++; $display("FAIL rd_pc0 got %h exp 00000100", pc0); end
        checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 32'h60) begin errors++; $display("FAIL rd_stale got %b/%h exp 1/00000060", mem_if.mem_req, mem_if.mem_addr); end
        drive(0, 0, 0, 0);
        drive(0, 1, 0, 0);
        checks++; if (count !== 4'd0 || pc0 !== 32'h100) begin errors++; $display("FAIL rd_discard got %0d/%h exp 0/00000100", count, pc0); end
        checks++; if (mem_if.mem_req !== 1'b0) begin errors++; $display("FAIL rd_idle got %b exp 0", mem_if.mem_req); end
        drive(0, 0, 0, 0);
        checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 32'h100) begin errors++; $display("FAIL rd_newreq got %b/%h exp 1/00000100", mem_if.mem_req, mem_if.mem_addr); end
        drive(0, 1, 0, 0);
        checks++; if (count !== 4'd6 || instr !== {32'h52, 32'h51}) begin errors++; $display("FAIL rd_data got %0d/%h exp 6/0000005200000051", count, instr); end
        checks++; if (instr[31:0] !== exp_q[0] || pc0 !== m_pc0) begin errors++; $display("FAIL rd_model got %h/%h exp %h/%h", instr[31:0], pc0, exp_q[0], m_pc0); end
    endtask

    task automatic test_redirect_with_ack();
        drive(0, 0, 0, 0);
        checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 32'h118) begin errors++; $display("FAIL rda_req got %b/%h exp 1/00000118", mem_if.mem_req, mem_if.mem_addr); end
        drive(1, 1, 1, 32'h200);
        checks++; if (count !== 4'd0 || instr_valid !== 2'b00) begin errors++; $display("FAIL rda_flush got %0d/%b exp 0/00", count, instr_valid); end
        checks++; if (pc0 !== 32'h200 || mem_if.mem_req !== 1'b0) begin errors++; $display("FAIL rda_state got %h/%b exp 00000200/0", pc0, mem_if.mem_req); end
        drive(0, 0, 0, 0);
        checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 32'h200) begin errors++; $display("FAIL rda_newreq got %b/%h exp 1/00000200", mem_if.mem_req, mem_if.mem_addr); end
    endtask

    task automatic test_reset_mid_fetch();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        checks++; if (mem_if.mem_req !== 1'b0 || mem_if.mem_addr !== 32'h0) begin errors++; $display("FAIL mid_rst got %b/%h exp 0/0", mem_if.mem_req, mem_if.mem_addr); end
        checks++; if (count !== 4'd0 || pc0 !== 32'h0) begin errors++; $display("FAIL mid_rst_state got %0d/%h exp 0/0", count, pc0); end
        drive(0, 1, 0, 0);
        checks++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL stale_ack got %0d/%b exp 0/1", count, empty); end
        checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 32'h0) begin errors++; $display("FAIL stale_req got %b/%h exp 1/0", mem_if.mem_req, mem_if.mem_addr); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_fetch();
        test_fill_drain();
        test_wrap();
        test_back_to_back();
        test_underflow();
        test_redirect_drain();
        test_redirect_with_ack();
        test_reset_mid_fetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Parametrised instruction fetch buffer between the instruction-memory bus and the dual-issue scheduler. It is a circular queue of DEPTH words filled in FETCH_W-word beats over a single-outstanding req/ack bus, and it presents up to ISSUE_W in-order instructions with per-slot valids and the PC of slot 0. It supports variable consumption (0..ISSUE_W per cycle) and a redirect/flush for taken branches, including discarding an in-flight response.

## Interface
- DEPTH, 12, buffer entries; DEPTH >= FETCH_W, DEPTH >= ISSUE_W; non-power-of-2 allowed
- FETCH_W, 6, 32-bit words returned per memory beat
- ISSUE_W, 2, instruction slots presented to scheduler
- RESET_PC, 32'h0000_0000, fetch and slot-0 PC after reset
- CW, $clog2(ISSUE_W+1), width of consume
- clk  in  1  clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- mem_req  out  1  fetch request, held until mem_ack
- mem_addr  out  32  byte address of first word of beat, word aligned
- mem_ack  in  1  response valid, single-cycle pulse
- mem_rdata  in  32*FETCH_W  word k at bits [32k+31:32k] = address mem_addr+4k
- consume  in  CW  instructions taken by scheduler this cycle (0 = freeze, 1 = dependency, 2 = full issue)
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (treated as 0)
- instr  out  32*ISSUE_W  slot i = buffer[(head+i) mod DEPTH]
- instr_valid  out  ISSUE_W  bit i = (count > i)
- pc0  out  32  PC of slot 0
- count  out  $clog2(DEPTH+1)  occupied entries
- empty  out  1  count == 0

## Operation
- State: head, tail (0..DEPTH-1, wrap mod DEPTH), count, fetch_pc, pc0, FSM {IDLE, REQ, DRAIN}, storage DEPTH x 32.
- Effective consume: eff = min(consume, count); excess consume is ignored. pc0 += 4*eff; head advances eff mod DEPTH.
- IDLE: if (DEPTH - count) >= FETCH_W, evaluated on the registered count, go to REQ. Otherwise stay.
- REQ: mem_req=1 and mem_addr=fetch_pc, both stable. On mem_ack: write FETCH_W words at tail..tail+FETCH_W-1 mod DEPTH, tail += FETCH_W, fetch_pc += 4*FETCH_W, go to IDLE.
- DRAIN: mem_req=1 with the stale address held until mem_ack. The response is discarded, then go to IDLE.
- Same-cycle ack and consume: both are applied; count_next = count + FETCH_W - eff. No overflow is possible because space was checked at request time and consume only frees entries.
- Redirect has priority over everything. Effects:
  - count=0, head=tail=0.
  - fetch_pc = pc0 = redirect_pc & ~3.
  - consume is ignored.
  - Next state:
    - In REQ without ack: go to DRAIN.
    - In REQ with ack: data discarded, go to IDLE.
    - In DRAIN without ack: stay DRAIN.
    - In DRAIN with ack: go to IDLE.
    - In IDLE: stay IDLE.
- Storage contents are not cleared on redirect; instr_valid gates them.
- Zero words are legal instructions; validity comes only from count, never from data value.

## Timing
- Reset values:
  - Registers: state IDLE, head=tail=count=0, fetch_pc=pc0=RESET_PC, storage all 0.
  - Outputs: mem_req=0, mem_addr=RESET_PC, instr=0, instr_valid=0, empty=1.
- rst asserted mid-fetch: all state returns to reset values next edge. A later mem_ack for the abandoned request arrives in IDLE and is ignored.
- mem_ack outside REQ/DRAIN is ignored.
- Outputs are driven from registers only; no combinational path from consume/mem_ack/redirect to outputs.
- First cycle after reset: IDLE. mem_req rises at the next edge, cycle 2.
- Ack in cycle N: new words are visible on instr/instr_valid in cycle N+1. Earliest next mem_req is cycle N+2 (IDLE for one cycle).
- Redirect in cycle N: instr_valid=0 and pc0=redirect_pc in cycle N+1.
  - No fetch outstanding: new mem_req at cycle N+2.
  - Fetch outstanding: new mem_req two cycles after the draining ack.
- consume in cycle N: slot shift visible in cycle N+1.

## Test plan
- Reset, then mem_ack 3 cycles after mem_req with words 0x11..0x16:
  - mem_req in cycle 2, mem_addr=0.
  - After ack: count=6, instr={0x12,0x11}, instr_valid=2'b11, pc0=0.
  - Next mem_addr=0x18 once space allows (space 6 >= 6, so immediately).
- Fill to 12, then consume=2 for three cycles:
  - count goes 12→10→8→6, and the refetch is issued only when space >= 6.
  - Slots are in program order; pc0=0x0,0x8,0x10,0x18.
- consume=1 repeatedly across the DEPTH wrap (head 11→0): instr slot1 comes from entry 0, with no gap or duplicate.
- count=1, consume=2: eff=1, count=0, empty=1, instr_valid=00, pc0 advanced by 4 only.
- Redirect to 0x103 while in REQ, then ack 2 cycles later:
  - Response discarded, count stays 0, pc0=0x100.
  - Next request has mem_addr=0x100.
- Same-cycle ack and consume=2 with count=4: count=8, head+2, pc0+8, and the written words are at the old tail.
